// File: rtl/dmem_arbiter_if.sv
// Handshake/bus bundle between the two requesters, the data memory and dmem_arbiter.
// slave = arbiter side, master = requester/memory side.
interface dmem_arbiter_if #(
   parameter int unsigned AW = 64,
   parameter int unsigned DW = 64
);
   logic          req0, req1;
   logic          rd0, rd1;
   logic          wr0, wr1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          ack0, ack1;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          gnt_id;
   logic          busy;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_read;
   logic          mem_write;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  req0, req1, rd0, rd1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_rdata,
      output ack0, ack1, rsp_rdata, rsp_err, gnt_id, busy,
             mem_addr, mem_wdata, mem_read, mem_write
   );

   modport master (
      output req0, req1, rd0, rd1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_rdata,
      input  ack0, ack1, rsp_rdata, rsp_err, gnt_id, busy,
             mem_addr, mem_wdata, mem_read, mem_write
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the 32x32-word data memory; fixed IDLE->ISSUE->RESP service.
// Define ARB_FIXED_PRIO_EN for fixed priority to requester 0 (default: round-robin).
module dmem_arbiter #(
   parameter int unsigned AW      = 64,
   parameter int unsigned DW      = 64,
   parameter int unsigned IDX_MAX = 31
) (
   input logic            clk,
   input logic            rst,
   dmem_arbiter_if.slave  bus
);
   localparam int unsigned     HW      = AW / 2;
   localparam logic [HW-1:0]   IDX_LIM = HW'(IDX_MAX);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   logic [1:0]    state_q, state_d;
   logic          ack0_q, ack0_d, ack1_q, ack1_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          err_q, err_d;
   logic          gnt_q, gnt_d;
   logic          last_q, last_d;
   logic [AW-1:0] maddr_q, maddr_d;
   logic [DW-1:0] mwdata_q, mwdata_d;
   logic          mread_q, mread_d, mwrite_q, mwrite_d;
   logic          op_rd_q, op_rd_d, op_err_q, op_err_d;

   logic          req0_eff, req1_eff, win;
   logic          sel_rd, sel_wr, oor;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   // A requester being acked this cycle is still holding its old request; keep it out of arbitration.
   assign req0_eff = bus.req0 & ~ack0_q;
   assign req1_eff = bus.req1 & ~ack1_q;

`ifdef ARB_FIXED_PRIO_EN
   assign win = ~req0_eff;
`else
   assign win = (req0_eff & req1_eff) ? ~last_q : req1_eff;
`endif

   assign sel_addr  = win ? bus.addr1  : bus.addr0;
   assign sel_wdata = win ? bus.wdata1 : bus.wdata0;
   assign sel_rd    = win ? bus.rd1    : bus.rd0;
   assign sel_wr    = win ? bus.wr1    : bus.wr0;
   assign oor       = (sel_addr[AW-1:HW] > IDX_LIM) || (sel_addr[HW-1:0] > IDX_LIM);

   always_comb begin
      state_d  = state_q;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      rdata_d  = rdata_q;
      err_d    = err_q;
      gnt_d    = gnt_q;
      last_d   = last_q;
      maddr_d  = maddr_q;
      mwdata_d = mwdata_q;
      mread_d  = mread_q;
      mwrite_d = mwrite_q;
      op_rd_d  = op_rd_q;
      op_err_d = op_err_q;
      case (state_q)
         ST_IDLE: begin
            if (req0_eff | req1_eff) begin
               state_d  = ST_ISSUE;
               gnt_d    = win;
               last_d   = win;
               maddr_d  = sel_addr;
               mwdata_d = sel_wdata;
               mwrite_d = sel_wr & ~oor;
               mread_d  = sel_rd & ~sel_wr & ~oor;
               op_rd_d  = sel_rd & ~sel_wr & ~oor;
               op_err_d = oor;
            end
         end
         ST_ISSUE: begin
            mread_d  = 1'b0;
            mwrite_d = 1'b0;
            state_d  = ST_RESP;
         end
         ST_RESP: begin
            rdata_d = op_rd_q ? bus.mem_rdata : '0;
            err_d   = op_err_q;
            ack0_d  = ~gnt_q;
            ack1_d  = gnt_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         gnt_q    <= 1'b0;
         last_q   <= 1'b1;
         maddr_q  <= '0;
         mwdata_q <= '0;
         mread_q  <= 1'b0;
         mwrite_q <= 1'b0;
         op_rd_q  <= 1'b0;
         op_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         gnt_q    <= gnt_d;
         last_q   <= last_d;
         maddr_q  <= maddr_d;
         mwdata_q <= mwdata_d;
         mread_q  <= mread_d;
         mwrite_q <= mwrite_d;
         op_rd_q  <= op_rd_d;
         op_err_q <= op_err_d;
      end
   end

   assign bus.ack0      = ack0_q;
   assign bus.ack1      = ack1_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign bus.gnt_id    = gnt_q;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.mem_addr  = maddr_q;
   assign bus.mem_wdata = mwdata_q;
   assign bus.mem_read  = mread_q;
   assign bus.mem_write = mwrite_q;
endmodule
